mem_stage_access: RTL
=====================

// Module: mem_stage_access
// PURPOSE
//  Memory-stage access sequencer, directly downstream of the Execute/Memory pipeline register.
//  Turns the scalar (N-bit) or vector (V-bit) load/store held in that register into
//  N-bit beats on the data-memory bus (req/gnt plus in-order rvalid).
//  Assembles load data for the Memory/Writeback register.
//  Raises MemBusyM to the hazard unit, which holds the pipeline until the access completes.
// PARAMETERS
//  N  32   scalar word width, data-bus width and address width
//  V  256  vector width; BEATS = V/N (8) is a localparam; V must be a multiple of N
// PORTS
//  clk         in   1  clock
//  rst         in   1  asynchronous, active-low reset
//  MemtoRegM   in   1  load requested
//  MemWriteM   in   1  store requested
//  MemDataVM   in   1  1 = vector access (BEATS beats), 0 = scalar access (1 beat)
//  ALUResultM  in   N  byte base address
//  WriteDataM  in   N  scalar store data
//  WriteDataVM in   V  vector store data; lane k = [k*N +: N]
//  MemBusyM    out  1  stall request to the hazard unit
//  ReadDataM   out  N  scalar load result
//  ReadDataVM  out  V  vector load result
//  mem_req     out  1  bus request
//  mem_we      out  1  1 = write beat
//  mem_addr    out  N  beat byte address
//  mem_wdata   out  N  beat write data
//  mem_gnt     in   1  beat accepted on a clk edge where mem_req & mem_gnt
//  mem_rvalid  in   1  read beat returned; returns are in order, at least 1 cycle after their grant
//  mem_rdata   in   N  read data, valid when mem_rvalid is high
// BEHAVIOUR
//  Reset: state IDLE, counters 0; MemBusyM=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
//   ReadDataM=0, ReadDataVM=0.
//   Reset asserted mid-access aborts immediately: mem_req drops asynchronously, partial load data is discarded.
//  access = MemtoRegM | MemWriteM. If both are high, the access is a write (load ignored).
//  States and transitions:
//   IDLE -> ISSUE when access. Latch op, vector flag, base address and store data.
//    Clear issue_cnt and ret_cnt.
//   ISSUE: mem_req=1, mem_we=op. mem_addr = base + 4*issue_cnt, mod 2^N (wraps).
//    mem_wdata = lane issue_cnt (vector) or WriteDataM (scalar).
//    Hold req/addr/we/wdata stable until a grant; each grant increments issue_cnt.
//    Grant of the last beat: write -> DONE; read -> WAIT_R. mem_req is 0 in the following cycle.
//   WAIT_R: mem_req=0. Stay until ret_cnt == beats, then -> DONE.
//   DONE: exactly 1 cycle, then -> IDLE. Inputs are not sampled in DONE.
//    This prevents re-issuing the instruction still held in the upstream register.
//  ret_cnt counts rvalid in ISSUE and WAIT_R, so rvalid may coincide with a grant.
//   On each rvalid, mem_rdata goes to lane ret_cnt of ReadDataVM (vector).
//   For a scalar read it goes to ReadDataM; the unused result is untouched.
//   A read completes on the edge of its last rvalid (ret_cnt reaches beats).
//  MemBusyM = (IDLE & access) | ISSUE | WAIT_R (combinational). It is 0 in DONE.
//   So the upstream register advances on the DONE edge.
//  Fully idle (no access, or DONE): MemBusyM=0; scalar latency then 0 cycles beyond the stage.
//  Minimum busy cycles: scalar write 2; scalar read 3; vector write BEATS+1; vector read BEATS+2.
//  Back-to-back memory ops: the next op is seen in IDLE 1 cycle after DONE.
//  rvalid in IDLE/DONE, or rvalid beyond the expected count, is ignored.
//  ReadDataM and ReadDataVM hold their values until overwritten by a later read.
// TESTING
//  Scalar write: A=0x100, D=0xDEADBEEF, gnt held 1 -> one beat with we=1 to 0x100.
//   MemBusyM high 2 cycles, then DONE, then IDLE.
//  Scalar read, gnt delayed 3 cycles, rvalid 2 cycles after grant, rdata=0x12345678.
//   -> req/addr stable while waiting; ReadDataM=0x12345678; MemBusyM drops in DONE.
//  Vector write: A=0x200, lanes 0..7 = 0x11..0x88, gnt low on beats 2 and 5 -> 8 beats.
//   Addresses 0x200..0x21C, wdata in lane order, no duplicate or skipped beat.
//  Vector read: rvalid each cycle, coinciding with grants, rdata=k+1 for beat k.
//   -> ReadDataVM lanes = 1..8; MemBusyM low exactly on the DONE cycle.
//  Address wrap: vector write at A=0xFFFFFFF8 -> beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0 .. 0x14.
//  Reset mid vector read after beat 3 -> mem_req and MemBusyM go 0 immediately, outputs 0, state IDLE.
//   A read issued after reset completes normally.

Source files
------------

// File: rtl/mem_stage_access.sv
// Memory-stage access sequencer: splits a scalar or vector load/store into N-bit bus
// beats, collects in-order read returns and stalls the pipeline until the access retires.
`timescale 1ns/1ps
module mem_stage_access #(
  parameter int N = 32,
  parameter int V = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         MemtoRegM,
  input  logic         MemWriteM,
  input  logic         MemDataVM,
  input  logic [N-1:0] ALUResultM,
  input  logic [N-1:0] WriteDataM,
  input  logic [V-1:0] WriteDataVM,
  output logic         MemBusyM,
  output logic [N-1:0] ReadDataM,
  output logic [V-1:0] ReadDataVM,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_gnt,
  input  logic         mem_rvalid,
  input  logic [N-1:0] mem_rdata
);

  localparam int BEATS = V / N;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT_R = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q;
  logic               op_we_q;
  logic               vec_q;
  logic [N-1:0]       base_q;
  logic [V-1:0]       wdv_q;
  logic [CNT_W-1:0]   issue_cnt_q;
  logic [CNT_W-1:0]   ret_cnt_q;
  logic               mem_req_q;
  logic               mem_we_q;
  logic [N-1:0]       mem_addr_q;
  logic [N-1:0]       mem_wdata_q;
  logic [N-1:0]       rd_q;
  logic [V-1:0]       rdv_q;

  logic [CNT_W-1:0]   issue_cnt_d;
  logic [CNT_W-1:0]   ret_cnt_d;
  logic [CNT_W-1:0]   beats_s;
  logic               access_s;
  logic               rv_take_s;

  function automatic logic [N-1:0] lane(input logic [V-1:0] v, input logic [IDX_W-1:0] idx);
    return v[idx*N +: N];
  endfunction

  function automatic logic [N-1:0] beat_addr(input logic [N-1:0] base, input logic [CNT_W-1:0] cnt);
    return base + N'({cnt, 2'b00});
  endfunction

  assign access_s    = MemtoRegM | MemWriteM;
  assign beats_s     = vec_q ? CNT_W'(BEATS) : CNT_W'(1);
  assign issue_cnt_d = issue_cnt_q + CNT_W'(1);
  assign ret_cnt_d   = ret_cnt_q + CNT_W'(1);
  // Returns are only accepted for a live read and never beyond the expected count.
  assign rv_take_s   = mem_rvalid & ~op_we_q & ((state_q == ISSUE) | (state_q == WAIT_R))
                     & (ret_cnt_q != beats_s);

  assign MemBusyM  = rst & (((state_q == IDLE) & access_s) | (state_q == ISSUE) | (state_q == WAIT_R));
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ReadDataM  = rd_q;
  assign ReadDataVM = rdv_q;

  // Access sequencer: beat issue, read-return capture and registered bus outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_we_q     <= 1'b0;
      vec_q       <= 1'b0;
      base_q      <= '0;
      wdv_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= '0;
      rdv_q       <= '0;
    end else begin
      if (rv_take_s) begin
        ret_cnt_q <= ret_cnt_d;
        if (vec_q) begin
          rdv_q[ret_cnt_q[IDX_W-1:0]*N +: N] <= mem_rdata;
        end else begin
          rd_q <= mem_rdata;
        end
      end
      case (state_q)
        IDLE: begin
          if (access_s) begin
            state_q     <= ISSUE;
            op_we_q     <= MemWriteM;
            vec_q       <= MemDataVM;
            base_q      <= ALUResultM;
            wdv_q       <= WriteDataVM;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= MemWriteM;
            mem_addr_q  <= ALUResultM;
            mem_wdata_q <= MemDataVM ? WriteDataVM[N-1:0] : WriteDataM;
          end
        end
        ISSUE: begin
          if (mem_gnt) begin
            issue_cnt_q <= issue_cnt_d;
            if (issue_cnt_d == beats_s) begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              state_q   <= op_we_q ? DONE : WAIT_R;
            end else begin
              mem_addr_q  <= beat_addr(base_q, issue_cnt_d);
              mem_wdata_q <= lane(wdv_q, issue_cnt_d[IDX_W-1:0]);
            end
          end
        end
        WAIT_R: begin
          if ((ret_cnt_q == beats_s) || (rv_take_s && (ret_cnt_d == beats_s))) begin
            state_q <= DONE;
          end
        end
        // One dead cycle so the instruction still upstream is not re-issued.
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          mem_we_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule
